// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry block.
package operand_entry_pkg;

  localparam int unsigned OPERAND_W = 4;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_entry_debounce.sv
// Level debouncer: the output follows the input only after it has disagreed
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sig != level) begin
      // Toggle on the cycle that would complete the run, so the level moves
      // exactly DEBOUNCE_CYCLES edges after the first disagreeing sample.
      if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Two-operand entry for a downstream adder: synchronized switches, debounced
// load button, clear button. Debouncing is enabled by OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_load,
  input  logic                 btn_clr,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic                 valid,
  output logic [1:0]           stage
);

  logic [OPERAND_W-1:0] sw_meta, sw_sync;
  logic                 load_meta, load_sync;
  logic                 clr_meta, clr_sync;
  logic                 load_level, load_prev, load_pulse;

  state_t               state, state_next;
  logic [OPERAND_W-1:0] a_next, b_next;
  logic                 valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      load_meta <= 1'b0;
      load_sync <= 1'b0;
      clr_meta  <= 1'b0;
      clr_sync  <= 1'b0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      load_meta <= btn_load;
      load_sync <= load_meta;
      clr_meta  <= btn_clr;
      clr_sync  <= clr_meta;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .sig  (load_sync),
    .level(load_level)
  );
`else
  logic unused_cfg;
  assign unused_cfg = DEBOUNCE_CYCLES[0];
  assign load_level = load_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      load_prev <= 1'b0;
    end else begin
      load_prev <= load_level;
    end
  end

  assign load_pulse = load_level & ~load_prev;

  always_comb begin
    state_next = state;
    a_next     = A;
    b_next     = B;
    valid_next = valid;
    if (clr_sync) begin
      state_next = WAIT_A;
      a_next     = '0;
      b_next     = '0;
      valid_next = 1'b0;
    end else if (load_pulse) begin
      case (state)
        WAIT_A: begin
          a_next     = sw_sync;
          state_next = WAIT_B;
        end
        WAIT_B: begin
          b_next     = sw_sync;
          valid_next = 1'b1;
          state_next = DONE;
        end
        DONE: begin
          a_next     = sw_sync;
          valid_next = 1'b0;
          state_next = WAIT_B;
        end
        default: state_next = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_A;
      A     <= '0;
      B     <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      A     <= a_next;
      B     <= b_next;
      valid <= valid_next;
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEBOUNCE_CYCLES=4; expected latency
// follows OPERAND_ENTRY_DEBOUNCE_EN.
module tb_operand_entry;

  localparam int unsigned DB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int unsigned LAT = DB + 3;
  localparam int unsigned PRE_RST_TICKS = 4;
`else
  localparam int unsigned LAT = 3;
  localparam int unsigned PRE_RST_TICKS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clr;
  logic [3:0] A;
  logic [3:0] B;
  logic       valid;
  logic [1:0] stage;

  int n_cmp  = 0;
  int n_fail = 0;

  operand_entry #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .btn_load(btn_load),
    .btn_clr (btn_clr),
    .A       (A),
    .B       (B),
    .valid   (valid),
    .stage   (stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       clr;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic       exp_valid;
    logic [1:0] exp_stage;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int ea, input int eb,
                           input int ev, input int es);
    check({name, ".A"}, int'(A), ea);
    check({name, ".B"}, int'(B), eb);
    check({name, ".valid"}, int'(valid), ev);
    check({name, ".stage"}, int'(stage), es);
  endtask

  task automatic press();
    btn_load = 1'b1;
    repeat (LAT + 2) tick();
    btn_load = 1'b0;
    repeat (LAT + 2) tick();
  endtask

  task automatic clear();
    btn_clr = 1'b1;
    repeat (3) tick();
    btn_clr = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    vecs[0] = '{sw: 4'd9,  clr: 1'b0, exp_a: 4'd5,  exp_b: 4'd9,  exp_valid: 1'b1, exp_stage: 2'd2};
    vecs[1] = '{sw: 4'd15, clr: 1'b0, exp_a: 4'd15, exp_b: 4'd9,  exp_valid: 1'b0, exp_stage: 2'd1};
    vecs[2] = '{sw: 4'd3,  clr: 1'b0, exp_a: 4'd15, exp_b: 4'd3,  exp_valid: 1'b1, exp_stage: 2'd2};
    vecs[3] = '{sw: 4'd0,  clr: 1'b1, exp_a: 4'd0,  exp_b: 4'd0,  exp_valid: 1'b0, exp_stage: 2'd0};
    vecs[4] = '{sw: 4'd0,  clr: 1'b0, exp_a: 4'd0,  exp_b: 4'd0,  exp_valid: 1'b0, exp_stage: 2'd1};
    vecs[5] = '{sw: 4'd15, clr: 1'b0, exp_a: 4'd0,  exp_b: 4'd15, exp_valid: 1'b1, exp_stage: 2'd2};

    rst = 1'b1; sw = 4'd0; btn_load = 1'b0; btn_clr = 1'b0;
    repeat (3) tick();
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // First press: exact raw-edge-to-capture latency.
    sw = 4'd5;
    repeat (3) tick();
    btn_load = 1'b1;
    repeat (LAT - 1) tick();
    check("lat_early.A", int'(A), 0);
    check("lat_early.stage", int'(stage), 0);
    tick();
    check_all("lat_edge", 5, 0, 0, 1);
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (LAT + 3) tick();
    check_all("release", 5, 0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      sw = vecs[i].sw;
      repeat (3) tick();
      if (vecs[i].clr) clear();
      else press();
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_a), int'(vecs[i].exp_b),
                int'(vecs[i].exp_valid), int'(vecs[i].exp_stage));
      if (i == 0) check("sum", int'({1'b0, A} + {1'b0, B}), 14);
    end

    // Bouncy press in DONE, then held: a single capture into A.
    sw = 4'd6;
    repeat (3) tick();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    for (int k = 0; k < 5; k++) begin
      btn_load = 1'b1;
      repeat (2) tick();
      btn_load = 1'b0;
      repeat (2) tick();
    end
    check_all("bounce", 0, 15, 1, 2);
`endif
    press();
    check_all("bounce_held", 6, 15, 0, 1);

    // Clear held across the load pulse: clear wins, nothing captured later.
    sw = 4'd7;
    repeat (3) tick();
    btn_load = 1'b1;
    btn_clr  = 1'b1;
    repeat (LAT + 2) tick();
    btn_clr = 1'b0;
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (LAT + 3) tick();
    check_all("clr_vs_load", 0, 0, 0, 0);

    // Reset landing in the middle of a press.
    sw = 4'd2;
    repeat (3) tick();
    press();
    check_all("pre_rst", 2, 0, 0, 1);
    sw = 4'd4;
    repeat (3) tick();
    btn_load = 1'b1;
    repeat (PRE_RST_TICKS) tick();
    rst = 1'b1;
    btn_load = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (LAT + 4) tick();
    check_all("rst_mid", 0, 0, 0, 0);

    // Button held through reset deassertion: one capture, usual latency.
    sw = 4'd8;
    btn_load = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (LAT - 1) tick();
    check("held_rst_early.A", int'(A), 0);
    tick();
    check_all("held_rst", 8, 0, 0, 1);
    repeat (LAT + 3) tick();
    btn_load = 1'b0;
    repeat (LAT + 3) tick();
    check_all("held_rst_once", 8, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
